// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bus: control/redirect inputs and the PC / IF-ID register outputs.
// The slave modport is the fetch stage; master is the surrounding pipeline.
interface if_fetch_stage_if #(
    parameter int unsigned XLEN = 64
);
    logic            stall;
    logic            switch;
    logic            Flush;
    logic [XLEN-1:0] branch_target;
    logic [31:0]     instr_in;
    logic [XLEN-1:0] pc_out;
    logic [XLEN-1:0] ifid_pc;
    logic [31:0]     ifid_instr;
    logic            ifid_valid;
    logic [15:0]     redirect_count;
    logic            misalign_err;

    modport master (
        output stall, switch, Flush, branch_target, instr_in,
        input  pc_out, ifid_pc, ifid_instr, ifid_valid, redirect_count, misalign_err
    );

    modport slave (
        input  stall, switch, Flush, branch_target, instr_in,
        output pc_out, ifid_pc, ifid_instr, ifid_valid, redirect_count, misalign_err
    );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC and the IF/ID register, applies branch
// redirects, flushes and load-use stalls, and counts taken redirects.
module if_fetch_stage #(
    parameter int unsigned     XLEN      = 64,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              reset,
    if_fetch_stage_if.slave   bus
);
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned INSTR_W = 32;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [XLEN-1:0]    pc_q,         pc_d;
    logic [XLEN-1:0]    ifid_pc_q,    ifid_pc_d;
    logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
    logic               ifid_valid_q, ifid_valid_d;
    logic [CNT_W-1:0]   redir_cnt_q,  redir_cnt_d;
    logic               misalign_q,   misalign_d;

    logic [XLEN-1:0]    pc_inc;

    assign pc_inc = pc_q + XLEN'(4);

    // Priority: redirect > flush > stall > normal fetch.
    always_comb begin
        pc_d         = pc_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        redir_cnt_d  = redir_cnt_q;
        misalign_d   = misalign_q;

        if (bus.switch) begin
            pc_d         = {bus.branch_target[XLEN-1:2], 2'b00};
            ifid_pc_d    = pc_q;
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
            if (redir_cnt_q != CNT_MAX) begin
                redir_cnt_d = redir_cnt_q + CNT_W'(1);
            end
            if (bus.branch_target[1:0] != 2'b00) begin
                misalign_d = 1'b1;
            end
        end else if (bus.Flush) begin
            ifid_pc_d    = pc_q;
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
            if (!bus.stall) begin
                pc_d = pc_inc;
            end
        end else if (!bus.stall) begin
            ifid_pc_d    = pc_q;
            ifid_instr_d = bus.instr_in;
            ifid_valid_d = 1'b1;
            pc_d         = pc_inc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            ifid_pc_q    <= '0;
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
            redir_cnt_q  <= '0;
            misalign_q   <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
            redir_cnt_q  <= redir_cnt_d;
            misalign_q   <= misalign_d;
        end
    end

    assign bus.pc_out         = pc_q;
    assign bus.ifid_pc        = ifid_pc_q;
    assign bus.ifid_instr     = ifid_instr_q;
    assign bus.ifid_valid     = ifid_valid_q;
    assign bus.redirect_count = redir_cnt_q;
    assign bus.misalign_err   = misalign_q;
endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios plus randomized traffic checked
// against a cycle-level behavioural model of the fetch rules.
module tb_if_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic reset;

    if_fetch_stage_if #(.XLEN(64)) bus ();

    if_fetch_stage #(.XLEN(64), .RESET_PC(64'h0), .NOP_INSTR(NOP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Behavioural model state
    logic [63:0] m_pc, m_ifid_pc;
    logic [31:0] m_instr;
    logic        m_valid, m_mis;
    int unsigned m_cnt;

    task automatic model_reset();
        m_pc = 64'h0; m_ifid_pc = 64'h0; m_instr = NOP;
        m_valid = 1'b0; m_cnt = 0; m_mis = 1'b0;
    endtask

    // Drive one cycle of inputs, clock it, advance the model, settle.
    task automatic step(input logic st, input logic sw, input logic fl,
                        input logic [63:0] tgt, input logic [31:0] ins);
        bus.stall = st; bus.switch = sw; bus.Flush = fl;
        bus.branch_target = tgt; bus.instr_in = ins;
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else if (sw) begin
            m_ifid_pc = m_pc;
            m_pc      = tgt & ~64'h3;
            m_instr   = NOP; m_valid = 1'b0;
            if (m_cnt < 65535) m_cnt++;
            if (tgt % 4 != 0) m_mis = 1'b1;
        end else if (fl) begin
            m_instr = NOP; m_valid = 1'b0;
            if (!st) m_pc = m_pc + 64'd4;
        end else if (!st) begin
            m_ifid_pc = m_pc; m_instr = ins; m_valid = 1'b1;
            m_pc = m_pc + 64'd4;
        end
        #1;
    endtask

    task automatic normal(input logic [31:0] ins);
        step(1'b0, 1'b0, 1'b0, 64'h0, ins);
    endtask

    task automatic test_reset();
        bus.stall = 1'b1; bus.switch = 1'b1; bus.Flush = 1'b1;
        bus.branch_target = 64'h500; bus.instr_in = 32'hDEAD_BEEF;
        reset = 1'b0;
        #2 reset = 1'b1;
        #1;
        model_reset();
        n_vec++; if (bus.pc_out !== 64'h0) begin n_err++; $display("FAIL reset_pc_async got %h want 0", bus.pc_out); end
        // pending redirect/stall must not act while reset is high
        step(1'b1, 1'b1, 1'b1, 64'h500, 32'hDEAD_BEEF);
        n_vec++; if (bus.pc_out !== 64'h0) begin n_err++; $display("FAIL reset_pc got %h want 0", bus.pc_out); end
        n_vec++; if (bus.ifid_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", bus.ifid_valid); end
        n_vec++; if (bus.ifid_instr !== NOP) begin n_err++; $display("FAIL reset_instr got %h want %h", bus.ifid_instr, NOP); end
        n_vec++; if (bus.redirect_count !== 16'h0) begin n_err++; $display("FAIL reset_cnt got %h want 0", bus.redirect_count); end
        n_vec++; if (bus.misalign_err !== 1'b0) begin n_err++; $display("FAIL reset_mis got %b want 0", bus.misalign_err); end
        reset = 1'b0;
    endtask

    task automatic test_seq_fetch();
        for (int i = 0; i < 4; i++) begin
            normal(32'h00A0_0093);
            n_vec++; if (bus.pc_out !== 64'(4 * (i + 1))) begin n_err++; $display("FAIL seq_pc[%0d] got %h want %h", i, bus.pc_out, 64'(4 * (i + 1))); end
            n_vec++; if (bus.ifid_pc !== 64'(4 * i)) begin n_err++; $display("FAIL seq_ifid_pc[%0d] got %h want %h", i, bus.ifid_pc, 64'(4 * i)); end
            n_vec++; if (bus.ifid_valid !== 1'b1) begin n_err++; $display("FAIL seq_valid[%0d] got %b want 1", i, bus.ifid_valid); end
            n_vec++; if (bus.ifid_instr !== 32'h00A0_0093) begin n_err++; $display("FAIL seq_instr[%0d] got %h", i, bus.ifid_instr); end
        end
    endtask

    task automatic test_branch();
        while (m_pc != 64'h20) normal($urandom);
        step(1'b0, 1'b1, 1'b1, 64'h100, $urandom);
        n_vec++; if (bus.pc_out !== 64'h100) begin n_err++; $display("FAIL br_pc got %h want 100", bus.pc_out); end
        n_vec++; if (bus.ifid_instr !== NOP) begin n_err++; $display("FAIL br_instr got %h want %h", bus.ifid_instr, NOP); end
        n_vec++; if (bus.ifid_valid !== 1'b0) begin n_err++; $display("FAIL br_valid got %b want 0", bus.ifid_valid); end
        n_vec++; if (bus.ifid_pc !== 64'h20) begin n_err++; $display("FAIL br_ifid_pc got %h want 20", bus.ifid_pc); end
        n_vec++; if (bus.redirect_count !== 16'd1) begin n_err++; $display("FAIL br_cnt got %0d want 1", bus.redirect_count); end
        normal(32'h1234_5678);
        n_vec++; if (bus.ifid_pc !== 64'h100) begin n_err++; $display("FAIL br_tgt_pc got %h want 100", bus.ifid_pc); end
        n_vec++; if (bus.ifid_valid !== 1'b1) begin n_err++; $display("FAIL br_tgt_valid got %b want 1", bus.ifid_valid); end
    endtask

    task automatic test_stall();
        logic [63:0] e_ifid_pc;
        logic [31:0] e_instr;
        step(1'b0, 1'b1, 1'b0, 64'h3C, $urandom);
        normal(32'hA5A5_0001);
        e_ifid_pc = m_ifid_pc; e_instr = m_instr;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, 64'h0, $urandom);
            n_vec++; if (bus.pc_out !== 64'h40) begin n_err++; $display("FAIL stall_pc[%0d] got %h want 40", i, bus.pc_out); end
            n_vec++; if (bus.ifid_pc !== e_ifid_pc || bus.ifid_instr !== e_instr || bus.ifid_valid !== 1'b1) begin
                n_err++; $display("FAIL stall_ifid[%0d] got %h/%h/%b want %h/%h/1", i, bus.ifid_pc, bus.ifid_instr, bus.ifid_valid, e_ifid_pc, e_instr);
            end
        end
        normal(32'h0BAD_F00D);
        n_vec++; if (bus.pc_out !== 64'h44) begin n_err++; $display("FAIL stall_rel_pc got %h want 44", bus.pc_out); end
        n_vec++; if (bus.ifid_pc !== 64'h40 || bus.ifid_instr !== 32'h0BAD_F00D) begin n_err++; $display("FAIL stall_rel_ifid got %h/%h want 40/0badf00d", bus.ifid_pc, bus.ifid_instr); end
    endtask

    task automatic test_switch_stall();
        step(1'b1, 1'b1, 1'b0, 64'h200, $urandom);
        n_vec++; if (bus.pc_out !== 64'h200) begin n_err++; $display("FAIL swst_pc got %h want 200", bus.pc_out); end
        n_vec++; if (bus.ifid_valid !== 1'b0 || bus.ifid_instr !== NOP) begin n_err++; $display("FAIL swst_bubble got %b/%h want 0/%h", bus.ifid_valid, bus.ifid_instr, NOP); end
    endtask

    task automatic test_misalign();
        step(1'b0, 1'b1, 1'b1, 64'h103, $urandom);
        n_vec++; if (bus.pc_out !== 64'h100) begin n_err++; $display("FAIL mis_pc got %h want 100", bus.pc_out); end
        n_vec++; if (bus.misalign_err !== 1'b1) begin n_err++; $display("FAIL mis_set got %b want 1", bus.misalign_err); end
        for (int i = 0; i < 10; i++) begin
            normal($urandom);
            n_vec++; if (bus.misalign_err !== 1'b1) begin n_err++; $display("FAIL mis_sticky[%0d] got %b want 1", i, bus.misalign_err); end
        end
        reset = 1'b1; #1;
        model_reset();
        n_vec++; if (bus.misalign_err !== 1'b0) begin n_err++; $display("FAIL mis_clear got %b want 0", bus.misalign_err); end
        @(posedge clk); #1 reset = 1'b0;
    endtask

    task automatic test_wrap();
        step(1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, $urandom);
        n_vec++; if (bus.pc_out !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_err++; $display("FAIL wrap_tgt got %h", bus.pc_out); end
        normal(32'h0000_00EF);
        n_vec++; if (bus.pc_out !== 64'h0) begin n_err++; $display("FAIL wrap_pc got %h want 0", bus.pc_out); end
        n_vec++; if (bus.ifid_pc !== 64'hFFFF_FFFF_FFFF_FFFC || bus.ifid_valid !== 1'b1) begin n_err++; $display("FAIL wrap_ifid got %h/%b", bus.ifid_pc, bus.ifid_valid); end
    endtask

    task automatic test_random();
        logic st, sw, fl;
        logic [63:0] tgt;
        for (int i = 0; i < 400; i++) begin
            sw  = ($urandom_range(0, 5) == 0);
            fl  = sw ? 1'($urandom) : ($urandom_range(0, 7) == 0);
            st  = ($urandom_range(0, 3) == 0);
            tgt = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
            step(st, sw, fl, tgt, $urandom);
            n_vec++; if (bus.pc_out !== m_pc) begin n_err++; $display("FAIL rnd_pc[%0d] got %h want %h", i, bus.pc_out, m_pc); end
            n_vec++; if (bus.ifid_valid !== m_valid || bus.ifid_instr !== m_instr) begin n_err++; $display("FAIL rnd_ifid[%0d] got %b/%h want %b/%h", i, bus.ifid_valid, bus.ifid_instr, m_valid, m_instr); end
            if (m_valid) begin
                n_vec++; if (bus.ifid_pc !== m_ifid_pc) begin n_err++; $display("FAIL rnd_ifid_pc[%0d] got %h want %h", i, bus.ifid_pc, m_ifid_pc); end
            end
            n_vec++; if (bus.redirect_count !== 16'(m_cnt) || bus.misalign_err !== m_mis) begin n_err++; $display("FAIL rnd_cnt_mis[%0d] got %0d/%b want %0d/%b", i, bus.redirect_count, bus.misalign_err, m_cnt, m_mis); end
        end
    endtask

    task automatic test_saturation();
        reset = 1'b1; #1;
        model_reset();
        @(posedge clk); #1 reset = 1'b0;
        for (int i = 1; i <= 65537; i++) begin
            step(1'b0, 1'b1, 1'b1, {$urandom, $urandom} & ~64'h3, $urandom);
            if (i == 65534 || i == 65535 || i == 65537) begin
                n_vec++; if (bus.redirect_count !== 16'(m_cnt)) begin n_err++; $display("FAIL sat_cnt[%0d] got %h want %h", i, bus.redirect_count, 16'(m_cnt)); end
            end
        end
        n_vec++; if (bus.redirect_count !== 16'hFFFF) begin n_err++; $display("FAIL sat_final got %h want ffff", bus.redirect_count); end
    endtask

    initial begin
        reset = 1'b1;
        bus.stall = 1'b0; bus.switch = 1'b0; bus.Flush = 1'b0;
        bus.branch_target = '0; bus.instr_in = '0;
        model_reset();
        @(posedge clk); #1;
        test_reset();
        test_seq_fetch();
        test_branch();
        test_stall();
        test_switch_stall();
        test_misalign();
        test_wrap();
        test_random();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
